am2949_busctl: RTL

AM2949_BUSCTL -- requirements
Module: am2949_busctl

---
 rtl/am2949_busctl.sv | 95 +++++++++
 1 files changed

// File: rtl/am2949_busctl.sv
// Bidirectional bus transceiver controller: round-robin A/B grants with a
// dead TURN phase between driving phases. Define AM2949_BUSCTL_MAXHOLD_EN to force contended release.
module am2949_busctl #(
    parameter int TURNAROUND = 1,
    parameter int MAXHOLD    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic reqa,
    input  logic reqb,
    output logic gnta,
    output logic gntb,
    output logic tr_,
    output logic rc_,
    output logic busy
);
    typedef enum logic [1:0] {IDLE, ATOB, BTOA, TURN} state_t;

    localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);

    state_t     state_q, state_d;
    logic [3:0] turn_q, turn_d;
    logic       last_b_q, last_b_d;   // 1: B was served most recently
    logic       hold_done;

`ifdef AM2949_BUSCTL_MAXHOLD_EN
    localparam logic [7:0] HOLD_LIM = 8'(MAXHOLD - 1);
    logic [7:0] hold_q, hold_d;
    assign hold_done = (hold_q >= HOLD_LIM);
`else
    assign hold_done = 1'b0;
`endif

    function automatic state_t pick(input logic a, input logic b, input logic last_b);
        if (a && (!b || last_b)) return ATOB;
        else if (b)              return BTOA;
        else                     return IDLE;
    endfunction

    always_comb begin
        state_d  = state_q;
        turn_d   = turn_q;
        last_b_d = last_b_q;
        case (state_q)
            IDLE: state_d = pick(reqa, reqb, last_b_q);
            ATOB: if (!reqa || (reqb && hold_done)) state_d = TURN;
            BTOA: if (!reqb || (reqa && hold_done)) state_d = TURN;
            TURN: begin
                if (turn_q == TURN_LAST) state_d = pick(reqa, reqb, last_b_q);
                else                     turn_d  = turn_q + 4'd1;
            end
        endcase
        if (state_d == TURN && state_q != TURN) turn_d = 4'd0;
        if ((state_d == ATOB || state_d == BTOA) && (state_q == IDLE || state_q == TURN))
            last_b_d = (state_d == BTOA);
    end

`ifdef AM2949_BUSCTL_MAXHOLD_EN
    // Counter restarts on entry to a driving phase and saturates at 255.
    always_comb begin
        hold_d = hold_q;
        if (state_q == IDLE || state_q == TURN) hold_d = 8'd0;
        else if (hold_q != 8'hFF)               hold_d = hold_q + 8'd1;
    end
`endif

    // Outputs are registered from the next state so they change with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            turn_q   <= 4'd0;
            last_b_q <= 1'b1;
`ifdef AM2949_BUSCTL_MAXHOLD_EN
            hold_q   <= 8'd0;
`endif
            gnta     <= 1'b0;
            gntb     <= 1'b0;
            tr_      <= 1'b1;
            rc_      <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            turn_q   <= turn_d;
            last_b_q <= last_b_d;
`ifdef AM2949_BUSCTL_MAXHOLD_EN
            hold_q   <= hold_d;
`endif
            gnta     <= (state_d == ATOB);
            gntb     <= (state_d == BTOA);
            tr_      <= (state_d != ATOB);
            rc_      <= (state_d != BTOA);
            busy     <= (state_d != IDLE);
        end
    end
endmodule
